// File: rtl/multicycle_main_controller_if.sv
// Control bundle between the multi-cycle main controller (master) and the
// datapath it steers (slave): opcode/flags in, enables, mux selects and debug state out.
interface multicycle_main_controller_if #(
  parameter int ALUOP_W = 2
);
  logic [6:0]         opCode;
  logic               zero;
  logic               memReady;
  logic               pcWrite;
  logic               irWrite;
  logic               adrSrc;
  logic               memRead;
  logic               memWrite;
  logic               regWrite;
  logic [1:0]         aluSrcA;
  logic [1:0]         aluSrcB;
  logic [1:0]         resultSrc;
  logic [ALUOP_W-1:0] ALUOp;
  logic               trap;
  logic [3:0]         state;

  modport master (
    input  opCode, zero, memReady,
    output pcWrite, irWrite, adrSrc, memRead, memWrite, regWrite,
           aluSrcA, aluSrcB, resultSrc, ALUOp, trap, state
  );

  modport slave (
    output opCode, zero, memReady,
    input  pcWrite, irWrite, adrSrc, memRead, memWrite, regWrite,
           aluSrcA, aluSrcB, resultSrc, ALUOp, trap, state
  );
endinterface

// File: rtl/multicycle_main_controller.sv
// Multi-cycle RISC-V main controller: Moore FSM with memory wait/timeout and sticky trap.
// Optional macro CUSTOM_ADDI3_EN adds opcode 0000010 as an I-type op with ALUOp=11.
module multicycle_main_controller #(
  parameter int ALUOP_W     = 2,
  parameter int MEM_TIMEOUT = 15
) (
  input logic                          clk,
  input logic                          reset,
  multicycle_main_controller_if.master bus
);

  localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BEQ      = 4'd9;
  localparam logic [3:0] S_JALR     = 4'd10;
  localparam logic [3:0] S_JUMP     = 4'd11;
  localparam logic [3:0] S_TRAP     = 4'd12;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_CUSTOM = 7'b0000010;

  logic [3:0]         r_state;
  logic [3:0]         w_next;
  logic [CNT_W-1:0]   r_wait_cnt;
  logic               r_trap;
  logic               w_wait_state;
  logic               w_timeout;

  logic               w_pc_write;
  logic               w_ir_write;
  logic               w_adr_src;
  logic               w_mem_read;
  logic               w_mem_write;
  logic               w_reg_write;
  logic [1:0]         w_alu_src_a;
  logic [1:0]         w_alu_src_b;
  logic [1:0]         w_result_src;
  logic [ALUOP_W-1:0] w_alu_op;

  assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEMREAD) ||
                        (r_state == S_MEMWRITE);
  assign w_timeout    = (MEM_TIMEOUT > 0) && w_wait_state && !bus.memReady &&
                        (r_wait_cnt == CNT_W'(MEM_TIMEOUT));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH: begin
        if (bus.memReady)   w_next = S_DECODE;
        else if (w_timeout) w_next = S_TRAP;
      end
      S_DECODE: begin
        case (bus.opCode)
          OP_LOAD, OP_STORE: w_next = S_MEMADR;
          OP_RTYPE:          w_next = S_EXECR;
          OP_ITYPE:          w_next = S_EXECI;
          OP_BRANCH:         w_next = S_BEQ;
          OP_JAL:            w_next = S_JUMP;
          OP_JALR:           w_next = S_JALR;
`ifdef CUSTOM_ADDI3_EN
          OP_CUSTOM:         w_next = S_EXECI;
`endif
          default:           w_next = S_TRAP;
        endcase
      end
      S_MEMADR:   w_next = (bus.opCode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: begin
        if (bus.memReady)   w_next = S_MEMWB;
        else if (w_timeout) w_next = S_TRAP;
      end
      S_MEMWB:    w_next = S_FETCH;
      S_MEMWRITE: begin
        if (bus.memReady)   w_next = S_FETCH;
        else if (w_timeout) w_next = S_TRAP;
      end
      S_EXECR:    w_next = S_ALUWB;
      S_EXECI:    w_next = S_ALUWB;
      S_ALUWB:    w_next = S_FETCH;
      S_BEQ:      w_next = S_FETCH;
      S_JALR:     w_next = S_JUMP;
      S_JUMP:     w_next = S_ALUWB;
      S_TRAP:     w_next = S_TRAP;
      default:    w_next = S_TRAP;
    endcase
  end

  // Wait counter restarts whenever the state changes, so every access gets a fresh budget
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_FETCH;
      r_wait_cnt <= '0;
      r_trap     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state)
        r_wait_cnt <= '0;
      else if ((MEM_TIMEOUT > 0) && w_wait_state && !bus.memReady)
        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
      if (w_next == S_TRAP)
        r_trap <= 1'b1;
    end
  end

  always_comb begin
    w_pc_write   = 1'b0;
    w_ir_write   = 1'b0;
    w_adr_src    = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_reg_write  = 1'b0;
    w_alu_src_a  = 2'b00;
    w_alu_src_b  = 2'b00;
    w_result_src = 2'b00;
    w_alu_op     = '0;
    case (r_state)
      S_FETCH: begin
        w_mem_read   = 1'b1;
        w_alu_src_b  = 2'b10;
        w_result_src = 2'b10;
        w_ir_write   = bus.memReady;
        w_pc_write   = bus.memReady;
      end
      S_DECODE: begin
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b01;
      end
      S_MEMREAD: begin
        w_mem_read = 1'b1;
        w_adr_src  = 1'b1;
      end
      S_MEMWB: begin
        w_result_src = 2'b01;
        w_reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        w_mem_write = 1'b1;
        w_adr_src   = 1'b1;
      end
      S_EXECR: begin
        w_alu_src_a = 2'b10;
        w_alu_op    = ALUOP_W'(2'b10);
      end
      S_EXECI: begin
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b01;
        w_alu_op    = ALUOP_W'(2'b10);
`ifdef CUSTOM_ADDI3_EN
        if (bus.opCode == OP_CUSTOM) w_alu_op = ALUOP_W'(2'b11);
`endif
      end
      S_ALUWB:  w_reg_write = 1'b1;
      S_BEQ: begin
        w_alu_src_a = 2'b10;
        w_alu_op    = ALUOP_W'(2'b01);
        w_pc_write  = bus.zero;
      end
      S_JALR: begin
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b01;
      end
      // PC takes the target held in ALUOut while the ALU forms the link value oldPC+4
      S_JUMP: begin
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b10;
        w_pc_write  = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.pcWrite   = w_pc_write  & ~reset;
  assign bus.irWrite   = w_ir_write  & ~reset;
  assign bus.adrSrc    = w_adr_src   & ~reset;
  assign bus.memRead   = w_mem_read  & ~reset;
  assign bus.memWrite  = w_mem_write & ~reset;
  assign bus.regWrite  = w_reg_write & ~reset;
  assign bus.aluSrcA   = reset ? 2'b00 : w_alu_src_a;
  assign bus.aluSrcB   = reset ? 2'b00 : w_alu_src_b;
  assign bus.resultSrc = reset ? 2'b00 : w_result_src;
  assign bus.ALUOp     = reset ? '0 : w_alu_op;
  assign bus.trap      = r_trap;
  assign bus.state     = r_state;

endmodule

// File: tb/tb_multicycle_main_controller.sv
// Randomized bench for multicycle_main_controller: each instruction is modelled as its
// expected state path, with per-state output table, wait counting and sticky trap.
module tb_multicycle_main_controller;

  localparam int ALUOP_W     = 2;
  localparam int MEM_TIMEOUT = 15;
`ifdef CUSTOM_ADDI3_EN
  localparam bit CUSTOM_EN = 1'b1;
`else
  localparam bit CUSTOM_EN = 1'b0;
`endif

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_CUST = 7'b0000010;
  localparam logic [6:0] OP_BAD  = 7'b1111111;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_main_controller_if #(.ALUOP_W(ALUOP_W)) bus ();

  multicycle_main_controller #(
    .ALUOP_W     (ALUOP_W),
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  int m_path[$];
  int m_idx;
  int m_wait;
  bit m_trapped;

  logic [6:0] legal_ops [7];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int m_state();
    return m_trapped ? 12 : m_path[m_idx];
  endfunction

  function automatic int lat_of(input logic [6:0] op);
    case (op)
      OP_LW:   return 5;
      OP_SW:   return 4;
      OP_R:    return 4;
      OP_I:    return 4;
      OP_BEQ:  return 3;
      OP_JAL:  return 4;
      OP_JALR: return 5;
      default: return 0;
    endcase
  endfunction

  task automatic load_path(input logic [6:0] op);
    m_path = {0, 1};
    case (op)
      OP_LW:   begin m_path.push_back(2); m_path.push_back(3); m_path.push_back(4); end
      OP_SW:   begin m_path.push_back(2); m_path.push_back(5); end
      OP_R:    begin m_path.push_back(6); m_path.push_back(8); end
      OP_I:    begin m_path.push_back(7); m_path.push_back(8); end
      OP_BEQ:  m_path.push_back(9);
      OP_JAL:  begin m_path.push_back(11); m_path.push_back(8); end
      OP_JALR: begin m_path.push_back(10); m_path.push_back(11); m_path.push_back(8); end
      default: begin
        if (CUSTOM_EN && op == OP_CUST) begin m_path.push_back(7); m_path.push_back(8); end
        else m_path.push_back(12);
      end
    endcase
    m_idx  = 0;
    m_wait = 0;
  endtask

  // {pcWrite,irWrite,adrSrc,memRead,memWrite,regWrite,aluSrcA,aluSrcB,resultSrc,ALUOp,trap}
  function automatic logic [14:0] exp_out(input int st, input logic mr, input logic z,
                                          input logic [6:0] op);
    logic pcw, irw, adr, mrd, mwr, rgw, trp;
    logic [1:0] a, b, res, alu;
    {pcw, irw, adr, mrd, mwr, rgw, trp} = '0;
    a = 2'd0; b = 2'd0; res = 2'd0; alu = 2'd0;
    case (st)
      0:  begin mrd = 1'b1; b = 2'd2; res = 2'd2; irw = mr; pcw = mr; end
      1:  begin a = 2'd1; b = 2'd1; end
      2:  begin a = 2'd2; b = 2'd1; end
      3:  begin mrd = 1'b1; adr = 1'b1; end
      4:  begin res = 2'd1; rgw = 1'b1; end
      5:  begin mwr = 1'b1; adr = 1'b1; end
      6:  begin a = 2'd2; alu = 2'd2; end
      7:  begin a = 2'd2; b = 2'd1; alu = (CUSTOM_EN && op == OP_CUST) ? 2'd3 : 2'd2; end
      8:  rgw = 1'b1;
      9:  begin a = 2'd2; alu = 2'd1; pcw = z; end
      10: begin a = 2'd2; b = 2'd1; end
      11: begin a = 2'd1; b = 2'd2; pcw = 1'b1; end
      12: trp = 1'b1;
      default: ;
    endcase
    return {pcw, irw, adr, mrd, mwr, rgw, a, b, res, alu, trp};
  endfunction

  function automatic logic [14:0] obs_out();
    return {bus.pcWrite, bus.irWrite, bus.adrSrc, bus.memRead, bus.memWrite, bus.regWrite,
            bus.aluSrcA, bus.aluSrcB, bus.resultSrc, bus.ALUOp, bus.trap};
  endfunction

  task automatic advance(input logic mr);
    int cur;
    if (m_trapped) return;
    cur = m_path[m_idx];
    if ((cur == 0 || cur == 3 || cur == 5) && !mr) begin
      if (MEM_TIMEOUT > 0 && m_wait == MEM_TIMEOUT) m_trapped = 1'b1;
      else m_wait++;
    end else begin
      m_wait = 0;
      m_idx++;
      if (m_idx == m_path.size()) m_idx = 0;
      else if (m_path[m_idx] == 12) m_trapped = 1'b1;
    end
  endtask

  // Called at a negedge; checks outputs mid-low-phase, then advances across one posedge
  task automatic step(input logic mr, input logic z, output logic [14:0] ov);
    bus.memReady = mr;
    bus.zero     = z;
    #1;
    ov = obs_out();
    chk("state", 32'(bus.state), 32'(m_state()));
    chk("outs", 32'(ov), 32'(exp_out(m_state(), mr, z, bus.opCode)));
    @(posedge clk);
    advance(mr);
    @(negedge clk);
  endtask

  task automatic do_reset();
    bus.memReady = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_state", 32'(bus.state), 32'd0);
    chk("rst_outs", 32'(obs_out()), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset     = 1'b0;
    m_trapped = 1'b0;
    m_path    = {0};
    m_idx     = 0;
    m_wait    = 0;
  endtask

  task automatic run_instr(input logic [6:0] op, input bit rand_rdy, input int mem_lows,
                           input bit fetch_stall, input bit rand_z, input logic zfix,
                           output int cycles, output int n_memw, output int n_regw,
                           output int n_pcw);
    logic [14:0] ov;
    logic mr, z;
    int st, lows;
    bit started;
    bus.opCode = op;
    load_path(op);
    cycles = 0; n_memw = 0; n_regw = 0; n_pcw = 0;
    lows = mem_lows;
    started = 1'b0;
    do begin
      st = m_state();
      mr = 1'b1;
      if (rand_rdy) mr = ($urandom_range(0, 3) != 0);
      if ((st == 3 || st == 5) && lows > 0) begin mr = 1'b0; lows--; end
      if (st == 0 && fetch_stall) mr = 1'b0;
      z = rand_z ? 1'($urandom_range(0, 1)) : zfix;
      step(mr, z, ov);
      cycles++;
      n_pcw  += int'(ov[14]);
      n_memw += int'(ov[10]);
      n_regw += int'(ov[9]);
      if (m_idx != 0) started = 1'b1;
    end while (!m_trapped && !(started && m_idx == 0) && cycles < 100);
    chk("bounded", 32'(cycles < 100), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, nmw, nrw, npw;
    logic [14:0] ov;
    logic [6:0] op;
    legal_ops = '{OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL, OP_JALR};
    reset = 1'b1;
    bus.opCode = 7'd0;
    bus.zero = 1'b0;
    bus.memReady = 1'b0;
    m_path = {0};
    m_idx = 0; m_wait = 0; m_trapped = 1'b0;
    @(negedge clk);
    do_reset();

    run_instr(OP_LW, 0, 0, 0, 0, 1'b0, cyc, nmw, nrw, npw);
    chk("lw_lat", 32'(cyc), 32'd5);
    chk("lw_regw", 32'(nrw), 32'd1);

    run_instr(OP_SW, 0, 3, 0, 0, 1'b0, cyc, nmw, nrw, npw);
    chk("sw_cycles", 32'(cyc), 32'd7);
    chk("sw_memw", 32'(nmw), 32'd4);
    chk("sw_regw", 32'(nrw), 32'd0);

    run_instr(OP_BEQ, 0, 0, 0, 0, 1'b1, cyc, nmw, nrw, npw);
    chk("beq1_lat", 32'(cyc), 32'd3);
    chk("beq1_pcw", 32'(npw), 32'd2);
    run_instr(OP_BEQ, 0, 0, 0, 0, 1'b0, cyc, nmw, nrw, npw);
    chk("beq0_lat", 32'(cyc), 32'd3);
    chk("beq0_pcw", 32'(npw), 32'd1);

    run_instr(OP_JALR, 0, 0, 0, 0, 1'b0, cyc, nmw, nrw, npw);
    chk("jalr_lat", 32'(cyc), 32'd5);
    chk("jalr_pcw", 32'(npw), 32'd2);
    chk("jalr_regw", 32'(nrw), 32'd1);

    for (int i = 0; i < 7; i++) begin
      run_instr(legal_ops[i], 0, 0, 0, 0, 1'b0, cyc, nmw, nrw, npw);
      chk("latency", 32'(cyc), 32'(lat_of(legal_ops[i])));
    end

    // Ready arriving exactly at the timeout count completes the access
    run_instr(OP_LW, 0, MEM_TIMEOUT, 0, 0, 1'b0, cyc, nmw, nrw, npw);
    chk("edge_ok_cycles", 32'(cyc), 32'(5 + MEM_TIMEOUT));
    chk("edge_ok_trap", 32'(bus.trap), 32'd0);
    run_instr(OP_SW, 0, MEM_TIMEOUT + 1, 0, 0, 1'b0, cyc, nmw, nrw, npw);
    chk("edge_to_state", 32'(bus.state), 32'd12);
    chk("edge_to_trap", 32'(bus.trap), 32'd1);
    do_reset();

    run_instr(OP_BAD, 0, 0, 0, 0, 1'b0, cyc, nmw, nrw, npw);
    chk("ill_lat", 32'(cyc), 32'd2);
    for (int i = 0; i < 20; i++) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ov);
    chk("ill_trap", 32'(bus.trap), 32'd1);
    do_reset();
    chk("ill_cleared", 32'(bus.trap), 32'd0);

    run_instr(OP_CUST, 0, 0, 0, 0, 1'b0, cyc, nmw, nrw, npw);
    chk("cust_trap", 32'(bus.trap), 32'(!CUSTOM_EN));
    if (m_trapped) do_reset();

    run_instr(OP_LW, 0, 0, 1, 0, 1'b0, cyc, nmw, nrw, npw);
    chk("fetch_to_cycles", 32'(cyc), 32'(MEM_TIMEOUT + 1));
    chk("fetch_to_state", 32'(bus.state), 32'd12);
    step(1'b0, 1'b0, ov);
    do_reset();

    bus.opCode = OP_LW;
    load_path(OP_LW);
    for (int i = 0; i < 10 && m_state() != 3; i++) step(1'b1, 1'b0, ov);
    chk("in_memread", 32'(bus.state), 32'd3);
    do_reset();

    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 9) == 0) op = 7'($urandom_range(0, 127));
      else op = legal_ops[$urandom_range(0, 6)];
      run_instr(op, 1, 0, 0, 1, 1'b0, cyc, nmw, nrw, npw);
      if (m_trapped) begin
        for (int k = 0; k < 3; k++) step(1'($urandom_range(0, 1)), 1'b0, ov);
        do_reset();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
